// File: rtl/cascade_pkg.sv
// cascade_pkg: shared types and constants for the Viola-Jones cascade sequencer.
//   state_e            - sequencer FSM states
//   WORDS_PER_FEAT_DEF - ROM words per feature (P0, P1, threshold, left, right)
//   HDR_CNT_LSB/CNT_W  - position/width of the feature count in a stage header word
//   idx_w()            - width of a stage index (never below 1 bit)
package cascade_pkg;

  typedef enum logic [2:0] {
    IDLE, HDR_RD, HDR_CAP, FEAT, STHR, RES, FIN
  } state_e;

  localparam int WORDS_PER_FEAT_DEF = 5;
  localparam int HDR_CNT_LSB        = 0;
  localparam int CNT_W_DEF          = 12;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cascade_rom_addr_gen.sv
// cascade_rom_addr_gen: ROM word pointer and per-stage words-left down-counter.
//   clk_i/rst_i   clock, synchronous active-high reset
//   i_clr         restart pointer at 0 (new window)
//   i_rd          a read is issued this cycle at the current pointer
//   i_load        load words-left counter with i_load_val
//   i_dec         decrement words-left (feature read issued)
//   o_addr        read address; holds the last issued address while i_rd=0
//   o_words_left  remaining feature words for the current stage
module cascade_rom_addr_gen #(
  parameter int ROM_AW = 16,
  parameter int WL_W   = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_clr,
  input  logic              i_rd,
  input  logic              i_load,
  input  logic [WL_W-1:0]   i_load_val,
  input  logic              i_dec,
  output logic [ROM_AW-1:0] o_addr,
  output logic [WL_W-1:0]   o_words_left
);

  logic [ROM_AW-1:0] r_ptr;
  logic [ROM_AW-1:0] r_last;
  logic [WL_W-1:0]   r_left;

  // Pointer wraps modulo 2^ROM_AW by plain overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr  <= '0;
      r_last <= '0;
      r_left <= '0;
    end else begin
      if (i_clr)     r_ptr <= '0;
      else if (i_rd) r_ptr <= r_ptr + 1'b1;
      if (i_rd)      r_last <= r_ptr;
      if (i_load)     r_left <= i_load_val;
      else if (i_dec) r_left <= r_left - 1'b1;
    end
  end

  assign o_addr       = i_rd ? r_ptr : r_last;
  assign o_words_left = r_left;

endmodule

// File: rtl/cascade_sequencer.sv
// cascade_sequencer: walks the cascade ROM for one detection window.
//   Per stage: header read, N*WORDS_PER_FEAT feature reads, stage-threshold read,
//   then waits for the stage result; a failed stage ends the window early.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 begin cascade (accepted in IDLE only)
//   rom_rd_o/rom_addr_o     ROM read strobe/address, data returns next cycle
//   rom_data_i              ROM data (only header count field used)
//   wait_i                  parser stall, blocks feature/threshold reads
//   stage_threshold_val_o   threshold word is on rom_data_i this cycle
//   last_stage_o, done_o    one-cycle end-of-window pulses
//   stage_res_val_i/stage_pass_i  stage accumulator result
//   stage_idx_o, busy_o, face_o   status / decision
// Optional (macro CASCADE_STAT_EN): stages_run_o, rom_reads_o statistics.
module cascade_sequencer
  import cascade_pkg::*;
#(
  parameter  int ROM_AW         = 16,
  parameter  int NUM_STAGES     = 25,
  parameter  int WORDS_PER_FEAT = WORDS_PER_FEAT_DEF,
  parameter  int CNT_W          = CNT_W_DEF,
  localparam int SW             = idx_w(NUM_STAGES),
  localparam int SR_W           = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              rom_rd_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  input  logic              wait_i,
  output logic              stage_threshold_val_o,
  output logic              last_stage_o,
  input  logic              stage_res_val_i,
  input  logic              stage_pass_i,
  output logic [SW-1:0]     stage_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              face_o
`ifdef CASCADE_STAT_EN
  ,
  output logic [SR_W-1:0]   stages_run_o,
  output logic [31:0]       rom_reads_o
`endif
);

  // Feature words per stage; 3 extra bits cover WORDS_PER_FEAT up to 8.
  localparam int WL_W = CNT_W + 3;

  state_e          r_state, w_nxt;
  logic [SW-1:0]   r_stage;
  logic            r_face;
  logic            r_sthr_val;
  logic            w_rd, w_clr, w_load, w_dec;
  logic [WL_W-1:0] w_load_val, w_words_left;
  logic            w_last_stage;
  logic            w_unused_data;

  assign w_load_val    = WL_W'(rom_data_i[HDR_CNT_LSB +: CNT_W]) * WL_W'(WORDS_PER_FEAT);
  assign w_last_stage  = (r_stage == SW'(NUM_STAGES - 1));
  assign w_unused_data = ^rom_data_i;

  cascade_rom_addr_gen #(.ROM_AW(ROM_AW), .WL_W(WL_W)) u_addr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_clr        (w_clr),
    .i_rd         (w_rd),
    .i_load       (w_load),
    .i_load_val   (w_load_val),
    .i_dec        (w_dec),
    .o_addr       (rom_addr_o),
    .o_words_left (w_words_left)
  );

  always_comb begin
    w_nxt  = r_state;
    w_rd   = 1'b0;
    w_clr  = 1'b0;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      IDLE: if (start_i) begin
        w_clr = 1'b1;
        w_nxt = HDR_RD;
      end
      // Header is consumed here only, so it never waits on the parser.
      HDR_RD: begin
        w_rd  = 1'b1;
        w_nxt = HDR_CAP;
      end
      HDR_CAP: begin
        w_load = 1'b1;
        w_nxt  = (w_load_val == '0) ? STHR : FEAT;
      end
      FEAT: if (!wait_i) begin
        w_rd  = 1'b1;
        w_dec = 1'b1;
        if (w_words_left == WL_W'(1)) w_nxt = STHR;
      end
      STHR: if (!wait_i) begin
        w_rd  = 1'b1;
        w_nxt = RES;
      end
      RES: if (stage_res_val_i) begin
        w_nxt = (!stage_pass_i || w_last_stage) ? FIN : HDR_RD;
      end
      FIN:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_stage    <= '0;
      r_face     <= 1'b0;
      r_sthr_val <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      // Threshold data lands the cycle after its read strobe.
      r_sthr_val <= (r_state == STHR) && !wait_i;
      if (r_state == IDLE && start_i) begin
        r_stage <= '0;
        r_face  <= 1'b0;
      end else if (r_state == RES && stage_res_val_i) begin
        if (!stage_pass_i || w_last_stage) r_face  <= stage_pass_i;
        else                               r_stage <= r_stage + 1'b1;
      end
    end
  end

  assign rom_rd_o              = w_rd;
  assign stage_threshold_val_o = r_sthr_val;
  assign last_stage_o          = (r_state == FIN);
  assign done_o                = (r_state == FIN);
  assign busy_o                = (r_state != IDLE);
  assign stage_idx_o           = r_stage;
  assign face_o                = r_face;

`ifdef CASCADE_STAT_EN
  logic [SR_W-1:0] r_stages_run;
  logic [31:0]     r_rom_reads;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stages_run <= '0;
      r_rom_reads  <= '0;
    end else begin
      if (r_state == FIN) r_stages_run <= SR_W'(r_stage) + 1'b1;
      if (w_rd && r_rom_reads != '1) r_rom_reads <= r_rom_reads + 1'b1;
    end
  end

  assign stages_run_o = r_stages_run;
  assign rom_reads_o  = r_rom_reads;
`endif

endmodule

// File: tb/tb_cascade_sequencer.sv
// Self-checking bench for cascade_sequencer (NUM_STAGES=2). A reference model
// derives the expected ROM read sequence from stage headers and pass results.
module tb_cascade_sequencer;
  localparam int NS = 2;
  localparam int AW = 16;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  typedef int iq_t[$];

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, wait_r = 1'b0, rv = 1'b0, rp = 1'b0;
  logic [31:0] rom_data = '0;
  logic rom_rd, sthr, last_stage, busy, done, face;
  logic [AW-1:0] rom_addr;
  logic [SW-1:0] stage_idx;
`ifdef CASCADE_STAT_EN
  logic [$clog2(NS+1)-1:0] stages_run;
  logic [31:0] rom_reads;
`endif

  cascade_sequencer #(.ROM_AW(AW), .NUM_STAGES(NS), .WORDS_PER_FEAT(5), .CNT_W(12)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rom_rd_o(rom_rd), .rom_addr_o(rom_addr),
    .rom_data_i(rom_data), .wait_i(wait_r), .stage_threshold_val_o(sthr),
    .last_stage_o(last_stage), .stage_res_val_i(rv), .stage_pass_i(rp),
    .stage_idx_o(stage_idx), .busy_o(busy), .done_o(done), .face_o(face)
`ifdef CASCADE_STAT_EN
    , .stages_run_o(stages_run), .rom_reads_o(rom_reads)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [31:0] rom [0:1023];

  always @(posedge clk) rom_data <= rom_rd ? rom[rom_addr[9:0]] : $urandom;

  int  hdr_q[$], pass_q[$];
  int  exp_reads[$], exp_sthr[$], exp_hdr_addr[$];
  int  got_reads[$], got_sthr[$], got_cyc[$];
  bit  exp_face;
  int  exp_stages;
  int  got_done, got_face, got_idx;
  int  bad_last, bad_wait, bad_align, bad_busy;
  int  tb_reads;

  function automatic int first_diff(input iq_t a, input iq_t b);
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) return i;
    if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
    return -1;
  endfunction

  function automatic bit is_hdr(input int a);
    foreach (exp_hdr_addr[i]) if (exp_hdr_addr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Contiguous cascade layout: header, 5 words per feature, threshold word.
  task automatic build_model();
    int p = 0;
    logic [31:0] w;
    exp_reads.delete(); exp_sthr.delete(); exp_hdr_addr.delete();
    exp_face = 1'b1; exp_stages = 0;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    for (int s = 0; s < NS; s++) begin
      w = $urandom; w[11:0] = 12'(hdr_q[s]); rom[p] = w;
      exp_hdr_addr.push_back(p); exp_reads.push_back(p); p++;
      for (int k = 0; k < hdr_q[s] * 5; k++) begin exp_reads.push_back(p); p++; end
      exp_sthr.push_back(p); exp_reads.push_back(p); p++;
      exp_stages = s + 1;
      if (pass_q[s] == 0) begin exp_face = 1'b0; break; end
    end
  endtask

  // Drives one window; returns at done, at the abort address, or on timeout.
  task automatic run_window(input int wait_pct, input int stall_addr,
                            input bit start_in_res, input int abort_addr);
    int stall = 0, dly = 0, sidx = 0, last_addr = 0;
    bit pend = 1'b0;
    got_reads.delete(); got_sthr.delete(); got_cyc.delete();
    got_done = 0; got_face = 0; got_idx = -1;
    bad_last = 0; bad_wait = 0; bad_align = 0; bad_busy = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      rv = 1'b0; rp = 1'b0; start = (cyc == 0);
      if (stall > 0) begin wait_r = 1'b1; stall--; end
      else wait_r = ($urandom_range(0, 99) < wait_pct);
      if (pend) begin
        if (dly == 0) begin
          rv = 1'b1; rp = (sidx < pass_q.size()) ? pass_q[sidx][0] : 1'b0;
          pend = 1'b0; sidx++;
        end else begin
          dly--;
          if (start_in_res) start = 1'b1;
        end
      end
      @(negedge clk);
      if (last_stage !== done) bad_last++;
      if (cyc >= 1 && !busy) bad_busy++;
      if (rom_rd) begin
        if (wait_r && !is_hdr(int'(rom_addr))) bad_wait++;
        got_reads.push_back(int'(rom_addr)); got_cyc.push_back(cyc);
        last_addr = int'(rom_addr); tb_reads++;
        if (abort_addr >= 0 && int'(rom_addr) == abort_addr) return;
        if (stall_addr >= 0 && int'(rom_addr) == stall_addr) stall = 4;
      end
      if (sthr) begin
        got_sthr.push_back(last_addr);
        if (rom_data !== rom[last_addr]) bad_align++;
        pend = 1'b1;
        dly = start_in_res ? $urandom_range(1, 3) : $urandom_range(0, 3);
      end
      if (done) begin
        got_done = 1; got_face = int'(face); got_idx = int'(stage_idx);
        wait_r = 1'b0; return;
      end
    end
    wait_r = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({rom_rd, sthr, last_stage, busy, done, face} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 000000", {rom_rd, sthr, last_stage, busy, done, face});
    end
    n_tests++;
    if (rom_addr !== '0 || stage_idx !== '0) begin
      n_fail++; $display("FAIL reset_addr_idx got %0d/%0d want 0/0", rom_addr, stage_idx);
    end
    #1 rst = 1'b0; tb_reads = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || rom_rd !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_start busy=%b rd=%b want 0/0", busy, rom_rd);
    end
  endtask

  task automatic test_two_stage_pass();
    int d;
    hdr_q = '{2, 1}; pass_q = '{1, 1}; build_model();
    run_window(0, -1, 1'b0, -1);
    d = first_diff(got_reads, exp_reads);
    n_tests++;
    if (d >= 0) begin n_fail++; $display("FAIL two_stage_reads diff at %0d got %0d reads want %0d", d, got_reads.size(), exp_reads.size()); end
    d = first_diff(got_sthr, exp_sthr);
    n_tests++;
    if (d >= 0 || bad_align != 0) begin n_fail++; $display("FAIL two_stage_sthr diff at %0d misaligned %0d want -1/0", d, bad_align); end
    n_tests++;
    if (got_done != 1 || got_face != 1 || bad_last != 0) begin
      n_fail++; $display("FAIL two_stage_done done=%0d face=%0d last_bad=%0d want 1/1/0", got_done, got_face, bad_last);
    end
  endtask

  task automatic test_early_fail();
    hdr_q = '{3, 2}; pass_q = '{0, 1}; build_model();
    run_window(0, -1, 1'b0, -1);
    repeat (3) @(negedge clk) if (rom_rd) got_reads.push_back(int'(rom_addr));
    n_tests++;
    if (first_diff(got_reads, exp_reads) >= 0 || got_reads.size() != 17) begin
      n_fail++; $display("FAIL early_fail_reads got %0d reads want 17", got_reads.size());
    end
    n_tests++;
    if (got_done != 1 || got_face != 0 || got_idx != 0) begin
      n_fail++; $display("FAIL early_fail_done done=%0d face=%0d idx=%0d want 1/0/0", got_done, got_face, got_idx);
    end
  endtask

  task automatic test_wait_stall();
    int gap;
    hdr_q = '{2, 1}; pass_q = '{1, 1}; build_model();
    run_window(0, 3, 1'b0, -1);
    gap = (got_cyc.size() > 4) ? got_cyc[4] - got_cyc[3] : -1;
    n_tests++;
    if (gap != 5 || bad_wait != 0 || got_reads.size() < 5 || got_reads[4] != 4) begin
      n_fail++; $display("FAIL wait_stall gap=%0d reads_in_wait=%0d want 5/0", gap, bad_wait);
    end
    n_tests++;
    if (first_diff(got_reads, exp_reads) >= 0) begin
      n_fail++; $display("FAIL wait_stall_count got %0d reads want %0d", got_reads.size(), exp_reads.size());
    end
  endtask

  task automatic test_zero_header();
    hdr_q = '{0, 1}; pass_q = '{1, 0}; build_model();
    run_window(0, -1, 1'b0, -1);
    n_tests++;
    if (got_sthr.size() < 1 || got_sthr[0] != 1 || first_diff(got_reads, exp_reads) >= 0) begin
      n_fail++; $display("FAIL zero_hdr sthr0=%0d reads=%0d want 1/%0d",
                         (got_sthr.size() > 0) ? got_sthr[0] : -1, got_reads.size(), exp_reads.size());
    end
    n_tests++;
    if (got_face != 0 || got_idx != 1) begin
      n_fail++; $display("FAIL zero_hdr_dec face=%0d idx=%0d want 0/1", got_face, got_idx);
    end
  endtask

  task automatic test_start_in_res();
    hdr_q = '{1, 2}; pass_q = '{1, 1}; build_model();
    run_window(0, -1, 1'b1, -1);
    n_tests++;
    if (first_diff(got_reads, exp_reads) >= 0 || got_face != 1) begin
      n_fail++; $display("FAIL start_in_res reads=%0d face=%0d want %0d/1", got_reads.size(), got_face, exp_reads.size());
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || face !== 1'b1) begin
      n_fail++; $display("FAIL after_done busy=%b face=%b want 0/1", busy, face);
    end
`ifdef CASCADE_STAT_EN
    n_tests++;
    if (int'(stages_run) != 2 || int'(rom_reads) != tb_reads) begin
      n_fail++; $display("FAIL stats stages=%0d reads=%0d want 2/%0d", stages_run, rom_reads, tb_reads);
    end
`endif
  endtask

  task automatic test_reset_mid();
    hdr_q = '{3, 1}; pass_q = '{1, 1}; build_model();
    run_window(0, -1, 1'b0, 6);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_pre done=%b busy=%b want 0/1", done, busy);
    end
    @(posedge clk); #1 rst = 1'b0; tb_reads = 0;
    @(negedge clk);
    n_tests++;
    if ({rom_rd, sthr, last_stage, busy, done, face} !== 6'b0 || rom_addr !== '0 || stage_idx !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs flags=%b addr=%0d idx=%0d want 0/0/0",
                         {rom_rd, sthr, last_stage, busy, done, face}, rom_addr, stage_idx);
    end
    hdr_q = '{1, 1}; pass_q = '{1, 1}; build_model();
    run_window(0, -1, 1'b0, -1);
    n_tests++;
    if (first_diff(got_reads, exp_reads) >= 0 || got_done != 1) begin
      n_fail++; $display("FAIL reset_mid_restart first=%0d done=%0d want 0/1",
                         (got_reads.size() > 0) ? got_reads[0] : -1, got_done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      hdr_q = '{$urandom_range(0, 4), $urandom_range(0, 4)};
      pass_q = '{($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      build_model();
      run_window(30, -1, 1'b0, -1);
      n_tests++;
      if (first_diff(got_reads, exp_reads) >= 0 || first_diff(got_sthr, exp_sthr) >= 0) begin
        n_fail++; $display("FAIL rand%0d_reads got %0d/%0d want %0d/%0d", it,
                           got_reads.size(), got_sthr.size(), exp_reads.size(), exp_sthr.size());
      end
      n_tests++;
      if (got_done != 1 || got_face != int'(exp_face) || got_idx != exp_stages - 1) begin
        n_fail++; $display("FAIL rand%0d_dec done=%0d face=%0d idx=%0d want 1/%0d/%0d", it,
                           got_done, got_face, got_idx, exp_face, exp_stages - 1);
      end
      n_tests++;
      if (bad_wait != 0 || bad_align != 0 || bad_last != 0 || bad_busy != 0) begin
        n_fail++; $display("FAIL rand%0d_proto wait=%0d align=%0d last=%0d busy=%0d want 0", it,
                           bad_wait, bad_align, bad_last, bad_busy);
      end
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    test_reset();
    test_two_stage_pass();
    test_early_fail();
    test_wait_stall();
    test_zero_header();
    test_start_in_res();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
